// File: rtl/attractor_pkg.sv
// Shared encodings for the attractor sweep controller: result kinds, FSM states
// and the kind-to-counter mapping used by the statistics block.
package attractor_pkg;

  localparam logic [1:0] KIND_FIX   = 2'd0;
  localparam logic [1:0] KIND_CYCLE = 2'd1;
  localparam logic [1:0] KIND_TMO   = 2'd2;

  typedef logic [2:0] sweep_state_t;

  localparam sweep_state_t ST_IDLE   = 3'd0;
  localparam sweep_state_t ST_LOAD   = 3'd1;
  localparam sweep_state_t ST_RUN    = 3'd2;
  localparam sweep_state_t ST_REPORT = 3'd3;
  localparam sweep_state_t ST_DONE   = 3'd4;

  // Bit i of the result selects counter i (fix, cycle, timeout).
  function automatic logic [2:0] kind_onehot(input logic [1:0] kind);
    logic [2:0] oh;
    case (kind)
      KIND_FIX:   oh = 3'b001;
      KIND_CYCLE: oh = 3'b010;
      KIND_TMO:   oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sweep_stats.sv
// Three saturating aggregate counters (fix / cycle / timeout) with a common
// synchronous clear and a one-hot increment request.
module sweep_stats
  import attractor_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [2:0]       inc,
  output logic [CNT_W-1:0] fix_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] tmo_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] fix_cnt_q, fix_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Next counter values: clear wins over any increment request.
  always_comb begin
    fix_cnt_d   = fix_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    if (clr) begin
      fix_cnt_d   = '0;
      cycle_cnt_d = '0;
      tmo_cnt_d   = '0;
    end else begin
      fix_cnt_d   = sat_inc(fix_cnt_q,   inc[KIND_FIX]);
      cycle_cnt_d = sat_inc(cycle_cnt_q, inc[KIND_CYCLE]);
      tmo_cnt_d   = sat_inc(tmo_cnt_q,   inc[KIND_TMO]);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fix_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      fix_cnt_q   <= fix_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign fix_cnt   = fix_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
  assign tmo_cnt   = tmo_cnt_q;

endmodule

// File: rtl/attractor_sweep_ctrl.sv
// Sweep initiator for the gene network: loads every initial state, holds the
// network in reset, waits for fix/cycle/timeout and reports one record per state.
module attractor_sweep_ctrl
  import attractor_pkg::*;
#(
  parameter int N          = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000,
  parameter int STEP_W     = 16,
  parameter int CNT_W      = N + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [N-1:0]      x_in,
  output logic              net_n_reset,
  input  logic [N-1:0]      x_out,
  input  logic              cycle,
  input  logic              fix,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_init,
  output logic [1:0]        res_kind,
  output logic [N-1:0]      res_state,
  output logic [STEP_W-1:0] res_steps,
  output logic [CNT_W-1:0]  fix_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  tmo_cnt,
  output logic              busy,
  output logic              done
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TIMEOUT - 1);
  localparam logic [N-1:0]      X_LAST    = {N{1'b1}};

  sweep_state_t      state_q, state_d;
  logic [N-1:0]      x_in_q, x_in_d;
  logic [RC_W-1:0]   rst_ctr_q, rst_ctr_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              net_n_reset_q, net_n_reset_d;
  logic              res_valid_q, res_valid_d;
  logic [N-1:0]      res_init_q, res_init_d;
  logic [1:0]        res_kind_q, res_kind_d;
  logic [N-1:0]      res_state_q, res_state_d;
  logic [STEP_W-1:0] res_steps_q, res_steps_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ev_hit_s;
  logic [1:0]        ev_kind_s;
  logic              stats_clr_s;
  logic [2:0]        stats_inc_s;

  // Event arbitration while running: fix beats cycle beats timeout.
  always_comb begin
    ev_hit_s  = 1'b0;
    ev_kind_s = KIND_FIX;
    if (state_q != ST_RUN) begin
      ev_hit_s  = 1'b0;
      ev_kind_s = KIND_FIX;
    end else if (fix) begin
      ev_hit_s  = 1'b1;
      ev_kind_s = KIND_FIX;
    end else if (cycle) begin
      ev_hit_s  = 1'b1;
      ev_kind_s = KIND_CYCLE;
    end else if (step_q == STEP_LAST) begin
      ev_hit_s  = 1'b1;
      ev_kind_s = KIND_TMO;
    end else begin
      ev_hit_s  = 1'b0;
      ev_kind_s = KIND_FIX;
    end
  end

  // Sweep FSM, timers and result record next-state logic.
  always_comb begin
    state_d       = state_q;
    x_in_d        = x_in_q;
    rst_ctr_d     = rst_ctr_q;
    step_d        = step_q;
    net_n_reset_d = 1'b0;
    res_valid_d   = res_valid_q;
    res_init_d    = res_init_q;
    res_kind_d    = res_kind_q;
    res_state_d   = res_state_q;
    res_steps_d   = res_steps_q;
    stats_clr_s   = 1'b0;
    stats_inc_s   = 3'b000;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          x_in_d      = '0;
          rst_ctr_d   = '0;
          stats_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      ST_LOAD: begin
        if (rst_ctr_q == RC_LAST) begin
          state_d       = ST_RUN;
          step_d        = '0;
          net_n_reset_d = 1'b1;
        end else begin
          rst_ctr_d = rst_ctr_q + RC_W'(1);
        end
      end

      ST_RUN: begin
        step_d = step_q + STEP_W'(1);
        if (ev_hit_s) begin
          state_d       = ST_REPORT;
          net_n_reset_d = 1'b0;
          res_valid_d   = 1'b1;
          res_init_d    = x_in_q;
          res_kind_d    = ev_kind_s;
          res_state_d   = x_out;
          res_steps_d   = step_q + STEP_W'(1);
          stats_inc_s   = kind_onehot(ev_kind_s);
        end else begin
          net_n_reset_d = 1'b1;
        end
      end

      // Network stays frozen in reset until the sink takes the record.
      ST_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (x_in_q == X_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_LOAD;
            x_in_d    = x_in_q + N'(1);
            rst_ctr_d = '0;
          end
        end else begin
          res_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_REPORT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      x_in_q        <= '0;
      rst_ctr_q     <= '0;
      step_q        <= '0;
      net_n_reset_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_init_q    <= '0;
      res_kind_q    <= 2'd0;
      res_state_q   <= '0;
      res_steps_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_in_q        <= x_in_d;
      rst_ctr_q     <= rst_ctr_d;
      step_q        <= step_d;
      net_n_reset_q <= net_n_reset_d;
      res_valid_q   <= res_valid_d;
      res_init_q    <= res_init_d;
      res_kind_q    <= res_kind_d;
      res_state_q   <= res_state_d;
      res_steps_q   <= res_steps_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  sweep_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk       (clk),
    .reset     (reset),
    .clr       (stats_clr_s),
    .inc       (stats_inc_s),
    .fix_cnt   (fix_cnt),
    .cycle_cnt (cycle_cnt),
    .tmo_cnt   (tmo_cnt)
  );

  assign x_in        = x_in_q;
  assign net_n_reset = net_n_reset_q;
  assign res_valid   = res_valid_q;
  assign res_init    = res_init_q;
  assign res_kind    = res_kind_q;
  assign res_state   = res_state_q;
  assign res_steps   = res_steps_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_attractor_sweep_ctrl.sv
// Bench for attractor_sweep_ctrl: stub gene network, directed record table,
// corner-case sequences and randomized sweeps against a per-state result model.
module tb_attractor_sweep_ctrl;

  localparam int N          = 4;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 20;
  localparam int STEP_W     = 16;
  localparam int CNT_W      = 5;
  localparam int NS         = 1 << N;

  localparam int M_FIX  = 0;
  localparam int M_CYC  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              res_ready = 1'b0;
  logic              fix = 1'b0;
  logic              cycle = 1'b0;
  logic [N-1:0]      x_out = '0;
  logic [N-1:0]      x_in, res_init, res_state;
  logic              net_n_reset, res_valid, busy, done;
  logic [1:0]        res_kind;
  logic [STEP_W-1:0] res_steps;
  logic [CNT_W-1:0]  fix_cnt, cycle_cnt, tmo_cnt;

  attractor_sweep_ctrl #(
    .N (N), .RST_CYCLES (RST_CYCLES), .TIMEOUT (TIMEOUT), .STEP_W (STEP_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .x_in (x_in), .net_n_reset (net_n_reset),
    .x_out (x_out), .cycle (cycle), .fix (fix), .res_valid (res_valid), .res_ready (res_ready),
    .res_init (res_init), .res_kind (res_kind), .res_state (res_state), .res_steps (res_steps),
    .fix_cnt (fix_cnt), .cycle_cnt (cycle_cnt), .tmo_cnt (tmo_cnt), .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int ev_at;
    int kind;
    int steps;
    int st;
  } vec_t;

  vec_t vec [NS];
  int   mode_a [NS];
  int   ev_a [NS];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Stub network output at step k after release.
  function automatic int xout_at(input int i, input int k);
    if ((mode_a[i] == M_FIX || mode_a[i] == M_BOTH) && k >= ev_a[i]) return i;
    return i ^ (k & (NS - 1));
  endfunction

  // Expected record for initial state i: first detection step, or timeout.
  task automatic model(input int i, output int kind, output int steps, output int st);
    int k;
    if (mode_a[i] != M_NONE && ev_a[i] <= TIMEOUT - 1) begin
      k    = ev_a[i];
      kind = (mode_a[i] == M_CYC) ? 1 : 0;
    end else begin
      k    = TIMEOUT - 1;
      kind = 2;
    end
    steps = k + 1;
    st    = xout_at(i, k);
  endtask

  // Stub network: counts steps while released, random noise while held in reset.
  int scnt = 0;
  always @(negedge clk) begin
    int i;
    if (net_n_reset !== 1'b1) begin
      scnt  = 0;
      fix   = 1'($urandom_range(0, 1));
      cycle = 1'($urandom_range(0, 1));
      x_out = N'($urandom);
    end else begin
      i     = int'(x_in);
      fix   = (mode_a[i] == M_FIX || mode_a[i] == M_BOTH) && scnt >= ev_a[i];
      cycle = (mode_a[i] == M_CYC || mode_a[i] == M_BOTH) && scnt >= ev_a[i];
      x_out = N'(xout_at(i, scnt));
      scnt  = scnt + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_idx = 0, use_table = 1, rand_ready = 0, stall_en = 0, stall_cnt = 0, last_acc = -1;
  int cnt_m [3];
  logic [27:0] snap;

  // Sink + record monitor.
  always @(negedge clk) begin
    int ek, es, est;
    if (res_valid === 1'b1 && stall_en != 0 && res_init == N'(3) && stall_cnt < 10) begin
      res_ready = 1'b0;
      check("stall_net_held", 64'(net_n_reset), 64'(0));
      if (stall_cnt == 0) snap = {res_valid, net_n_reset, res_init, res_kind, res_state, res_steps};
      else check("stall_stable", 64'({res_valid, net_n_reset, res_init, res_kind, res_state, res_steps}), 64'(snap));
      stall_cnt++;
    end else begin
      res_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (res_valid === 1'b1 && res_ready) begin
      if (exp_idx >= NS) begin
        check("rec_extra", 64'(exp_idx), 64'(NS - 1));
      end else begin
        if (use_table != 0) begin
          ek = vec[exp_idx].kind; es = vec[exp_idx].steps; est = vec[exp_idx].st;
        end else begin
          model(exp_idx, ek, es, est);
        end
        check("rec_init",  64'(res_init),  64'(exp_idx));
        check("rec_kind",  64'(res_kind),  64'(ek));
        check("rec_steps", 64'(res_steps), 64'(es));
        check("rec_state", 64'(res_state), 64'(est));
        if (last_acc >= 0) check("rec_gap", 64'(cyc - last_acc >= RST_CYCLES + 2), 64'(1));
        last_acc = cyc;
        cnt_m[ek]++;
        exp_idx++;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_run_of(input int v, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (net_n_reset === 1'b1) && (x_in == N'(v));
    end
    check(name, 64'(ok), 64'(1));
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (done === 1'b1);
    end
    check(name, 64'(ok), 64'(1));
  endtask

  task automatic new_sweep_model();
    exp_idx  = 0;
    last_acc = -1;
    for (int k = 0; k < 3; k++) cnt_m[k] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NS; i++) vec[i] = '{M_FIX, 2, 0, 3, i};
    vec[5]  = '{M_BOTH, 2, 0, 3, 5};
    vec[7]  = '{M_NONE, 0, 2, TIMEOUT, 4};
    vec[10] = '{M_CYC, 4, 1, 5, 14};
    vec[12] = '{M_FIX, TIMEOUT - 1, 0, TIMEOUT, 12};
    vec[13] = '{M_CYC, 0, 1, 1, 13};
    for (int i = 0; i < NS; i++) begin
      mode_a[i] = vec[i].mode;
      ev_a[i]   = vec[i].ev_at;
    end
    new_sweep_model();

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_x_in", 64'(x_in), 64'(0));
    check("rst_net_n_reset", 64'(net_n_reset), 64'(0));
    check("rst_res_fields", 64'({res_init, res_kind, res_state, res_steps}), 64'(0));
    check("rst_counts", 64'({fix_cnt, cycle_cnt, tmo_cnt}), 64'(0));
    check("rst_busy_done", 64'({busy, done}), 64'(0));
    reset = 1'b0;

    // Noise on fix/cycle while idle must not start anything.
    repeat (6) @(negedge clk);
    check("idle_hold", 64'({busy, done, net_n_reset, res_valid}), 64'(0));

    // Directed sweep: table records, stall at x_in=3, stray start at x_in=6.
    stall_en = 1;
    pulse_start();
    check("load_busy", 64'({busy, net_n_reset}), 64'(2'b10));
    wait_run_of(6, 400, "reach_run_6");
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(1500, "sweep1_done");
    check("sweep1_records", 64'(exp_idx), 64'(NS));
    check("sweep1_stalls", 64'(stall_cnt), 64'(10));
    check("sweep1_fix_cnt", 64'(fix_cnt), 64'(13));
    check("sweep1_cycle_cnt", 64'(cycle_cnt), 64'(2));
    check("sweep1_tmo_cnt", 64'(tmo_cnt), 64'(1));
    check("sweep1_last_x", 64'(x_in), 64'(NS - 1));
    repeat (4) @(negedge clk);
    check("done_hold", 64'({done, busy, net_n_reset, res_valid}), 64'(4'b1000));
    check("done_cnt_hold", 64'(fix_cnt), 64'(13));
    stall_en = 0;

    // Start from DONE clears counters; reset during RUN of x_in=9 aborts.
    use_table = 0;
    for (int i = 0; i < NS; i++) begin
      mode_a[i] = M_FIX;
      ev_a[i]   = 2;
    end
    new_sweep_model();
    pulse_start();
    check("restart_counts", 64'({fix_cnt, cycle_cnt, tmo_cnt}), 64'(0));
    check("restart_x_in", 64'({x_in, busy, done}), 64'(2'b10));
    wait_run_of(9, 400, "reach_run_9");
    check("pre_reset_fix_cnt", 64'(fix_cnt), 64'(9));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_res_valid", 64'(res_valid), 64'(0));
    check("midrst_x_in", 64'(x_in), 64'(0));
    check("midrst_counts", 64'({fix_cnt, cycle_cnt, tmo_cnt}), 64'(0));
    check("midrst_state", 64'({busy, done, net_n_reset}), 64'(0));
    reset = 1'b0;
    new_sweep_model();
    pulse_start();
    wait_done(1500, "sweep2_done");
    check("sweep2_records", 64'(exp_idx), 64'(NS));
    check("sweep2_fix_cnt", 64'(fix_cnt), 64'(NS));

    // Randomized sweeps with random sink back-pressure.
    rand_ready = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NS; i++) begin
        mode_a[i] = $urandom_range(0, 3);
        ev_a[i]   = $urandom_range(0, TIMEOUT + 2);
      end
      new_sweep_model();
      pulse_start();
      wait_done(4000, "rand_done");
      check("rand_records", 64'(exp_idx), 64'(NS));
      check("rand_fix_cnt", 64'(fix_cnt), 64'(cnt_m[0]));
      check("rand_cycle_cnt", 64'(cycle_cnt), 64'(cnt_m[1]));
      check("rand_tmo_cnt", 64'(tmo_cnt), 64'(cnt_m[2]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/attractor_sweep_ctrl.md
Name: attractor_sweep_ctrl

Overview:
- Hardware replacement for bench-driven state sweeps: the initiator side of the gene network / attractor-checker interface.
- Walks every initial state 0..2^N-1 into the network's x_in. Holds the network and checkers in reset for a fixed number of cycles, then releases them.
- Waits for fix or cycle, or a step timeout. Reports one result record per initial state over a valid/ready handshake and keeps aggregate counts.
- Sits between gene_net/cycle_chk/fixed_chk and a result sink (logger, FIFO or CPU-side reader).

Parameters:
- N, 8, state width (x_in/x_out width); sweep covers 2^N initial states
- RST_CYCLES, 2, cycles net_n_reset is held low per initial state (>=1)
- TIMEOUT, 1000, max steps after release before declaring timeout (1..2^STEP_W-1)
- STEP_W, 16, width of step counter and res_steps
- CNT_W, N+1, width of aggregate counters (must hold 2^N)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins sweep from 0 when IDLE or DONE, ignored otherwise
- x_in  out  N  initial state driven to the network
- net_n_reset  out  1  active-low reset to gene_net/cycle_chk/fixed_chk
- x_out  in  N  current network state
- cycle  in  1  cycle detected (level, from cycle_chk)
- fix  in  1  fixed point detected (level, from fixed_chk)
- res_valid  out  1  result record valid
- res_ready  in  1  sink accepts record
- res_init  out  N  initial state of this record
- res_kind  out  2  0=fix, 1=cycle, 2=timeout
- res_state  out  N  x_out sampled at detection
- res_steps  out  STEP_W  cycles from release to detection (or TIMEOUT)
- fix_cnt / cycle_cnt / tmo_cnt  out  CNT_W each  aggregate counts
- busy  out  1  high in LOAD/RUN/REPORT
- done  out  1  high in DONE

Behaviour:
- Reset values:
  - state=IDLE; x_in=0; net_n_reset=0 (network held); res_valid=0; res_init/res_kind/res_state/res_steps=0.
  - All counters=0; busy=0; done=0.
- IDLE:
  - net_n_reset=0.
  - start -> LOAD with x_in=0, counters cleared, rst_ctr=0.
- LOAD:
  - net_n_reset=0 for exactly RST_CYCLES cycles.
  - Then -> RUN with step=0 and net_n_reset=1 from the first RUN cycle.
- RUN:
  - step increments each cycle.
  - Events are sampled registered (the cycle after assertion is observed).
  - fix=1 -> record kind 0; fix has priority when fix and cycle are high in the same cycle.
  - Else cycle=1 -> kind 1.
  - Else step==TIMEOUT-1 -> kind 2, res_state=x_out, res_steps=TIMEOUT.
  - On any event:
    - capture res_init=x_in, res_state=x_out, res_steps=step+1.
    - Increment the matching counter; counters saturate at all-ones.
    - -> REPORT.
  - net_n_reset stays 1.
- REPORT:
  - res_valid=1; record fields stable until the handshake.
  - net_n_reset=0: the network is frozen in reset while waiting.
  - res_valid&&res_ready -> res_valid=0 next cycle.
  - If x_in==2^N-1 -> DONE; else x_in+=1 -> LOAD.
  - Back-to-back records are separated by at least RST_CYCLES+1 cycles.
- DONE: done=1, net_n_reset=0, counters hold; start -> new sweep with counters cleared.
- Invariant: fix_cnt+cycle_cnt+tmo_cnt equals the number of accepted records.
- Wrap-around: x_in never wraps within a sweep. The last state 2^N-1 is reported; the sweep ends there, not at 2^N-2.
- start during LOAD/RUN/REPORT: ignored.
- reset mid-operation: immediate return to reset values next edge. Any pending record is dropped; res_valid drops.
- fix/cycle asserted during LOAD/REPORT/IDLE: ignored.

Decomposition:
- Package attractor_pkg:
  - kind encodings KIND_FIX/KIND_CYCLE/KIND_TMO.
  - FSM state enum IDLE/LOAD/RUN/REPORT/DONE.
- Sub-module sweep_stats: three saturating CNT_W counters with clear and one-hot increment.
- FSM, step/reset timers and result register remain in the top module.

Test Plan:
- N=4, RST_CYCLES=2, stub net with fix at x_out==x_in from step 3, res_ready=1, start -> 16 records res_init 0..15, all kind 0, res_steps=3; fix_cnt=16, done=1.
- Stub asserts fix and cycle same cycle for x_in=5 -> that record kind 0; cycle_cnt unchanged.
- Stub never asserts fix/cycle for x_in=7, TIMEOUT=20 -> record kind 2, res_steps=20; tmo_cnt=1; sweep continues to x_in=8.
- res_ready held 0 for 10 cycles at x_in=3 -> res_valid and fields stable all 10 cycles, net_n_reset=0; exactly one record accepted when ready rises.
- reset pulsed during RUN of x_in=9 -> next cycle res_valid=0, x_in=0, counters=0, state IDLE; later start restarts from 0.
- start pulsed mid-sweep -> ignored, record sequence uninterrupted; start in DONE clears counters and restarts from 0.
